// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
//
// Multi-channel programmable clock divider for board-level timebases
// (LED blink, display refresh, debounce sampling). Every channel divides clk
// by its own run-time divide value N. It runs either as a periodic 50% square
// wave (period 2N) or as a retriggerable one-shot timer (busy for N cycles).
// Each channel also produces a one-cycle tick at every terminal count.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   enable    in   [NUM_CH]  per-channel count enable (low pauses)
//   sync      in   global phase-align strobe (clears cnt/pulse/tick)
//   start     in   [NUM_CH]  per-channel one-shot trigger
//   cfg_we    in   configuration write strobe
//   cfg_ch    in   [CH_W]    channel addressed by cfg_we
//   cfg_div   in   [CNT_W]   new divide value N
//   cfg_mode  in   new mode: 0 = periodic, 1 = one-shot
//   pulse     out  [NUM_CH]  divided clock / one-shot window (registered)
//   tick      out  [NUM_CH]  terminal-count strobe (registered)
//   busy      out  [NUM_CH]  one-shot running (registered)
// -----------------------------------------------------------------------------
module multi_clock_divider #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 30,
    parameter int unsigned DIV_RST = 32'd1073741823,
    parameter int          CH_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic [NUM_CH-1:0] start,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel state
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_div [NUM_CH];
    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_busy;

    // Next-state values
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_div_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_mode_nxt;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic [NUM_CH-1:0] w_tick_nxt;
    logic [NUM_CH-1:0] w_busy_nxt;

    // Per-channel decode
    logic [NUM_CH-1:0] w_cfg_hit;
    logic [CNT_W-1:0]  w_eff_div [NUM_CH];
    logic [NUM_CH-1:0] w_eff_mode;
    logic [NUM_CH-1:0] w_start_ok;
    logic [NUM_CH-1:0] w_active;
    logic [NUM_CH-1:0] w_wrap;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_dec
            // Addresses beyond NUM_CH-1 never match any channel, so such
            // writes are dropped.
            assign w_cfg_hit[g]  = cfg_we && (cfg_ch == CH_W'(g));
            // A start in the same cycle as a cfg write is judged against the
            // configuration being written, not the old one.
            assign w_eff_div[g]  = w_cfg_hit[g] ? cfg_div  : r_div[g];
            assign w_eff_mode[g] = w_cfg_hit[g] ? cfg_mode : r_mode[g];
            assign w_start_ok[g] = start[g] && w_eff_mode[g] && (w_eff_div[g] != CNT_ZERO);
            // Periodic channels run whenever N is non-zero; one-shots only
            // while their window is open.
            assign w_active[g]   = enable[g] && (r_mode[g] ? r_busy[g] : (r_div[g] != CNT_ZERO));
            assign w_wrap[g]     = w_active[g] && (r_cnt[g] == (r_div[g] - CNT_ONE));
        end
    endgenerate

    // Next-state selection: cfg write > start > sync > counting > hold
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i]   = r_cnt[i];
            w_div_nxt[i]   = r_div[i];
            w_mode_nxt[i]  = r_mode[i];
            w_pulse_nxt[i] = r_pulse[i];
            w_busy_nxt[i]  = r_busy[i];
            w_tick_nxt[i]  = 1'b0;

            if (w_cfg_hit[i]) begin
                w_div_nxt[i]   = cfg_div;
                w_mode_nxt[i]  = cfg_mode;
                w_cnt_nxt[i]   = CNT_ZERO;
                // Clear, unless a simultaneous start opens a fresh window
                w_pulse_nxt[i] = w_start_ok[i];
                w_busy_nxt[i]  = w_start_ok[i];
            end else if (w_start_ok[i]) begin
                // Retrigger wins over a wrap, but the wrap's tick still fires
                w_cnt_nxt[i]   = CNT_ZERO;
                w_busy_nxt[i]  = 1'b1;
                w_pulse_nxt[i] = 1'b1;
                w_tick_nxt[i]  = w_wrap[i];
            end else if (sync) begin
                // Busy one-shots keep busy and simply restart their count
                w_cnt_nxt[i]   = CNT_ZERO;
                w_pulse_nxt[i] = 1'b0;
            end else if (w_wrap[i]) begin
                w_cnt_nxt[i]  = CNT_ZERO;
                w_tick_nxt[i] = 1'b1;
                if (r_mode[i]) begin
                    w_busy_nxt[i]  = 1'b0;
                    w_pulse_nxt[i] = 1'b0;
                end else begin
                    w_pulse_nxt[i] = ~r_pulse[i];
                end
            end else if (w_active[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end else begin
                // Paused or stalled: hold everything, tick stays low
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= CNT_ZERO;
                r_div[i] <= DIV_INIT;
            end
            r_mode  <= {NUM_CH{1'b0}};
            r_pulse <= {NUM_CH{1'b0}};
            r_tick  <= {NUM_CH{1'b0}};
            r_busy  <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_div[i] <= w_div_nxt[i];
            end
            r_mode  <= w_mode_nxt;
            r_pulse <= w_pulse_nxt;
            r_tick  <= w_tick_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign pulse = r_pulse;
    assign tick  = r_tick;
    assign busy  = r_busy;

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Directed bench for multi_clock_divider. Expected values are hand-derived
// from the cycle count since the relevant cfg write, start or sync edge.
// CH_W is widened to 3 so an out-of-range channel address (5) can be driven.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 30;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] enable;
    logic              sync;
    logic [NUM_CH-1:0] start;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    multi_clock_divider #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (32'd1073741823),
        .CH_W    (CH_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .start    (start),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .pulse    (pulse),
        .tick     (tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle configuration write
    task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = dv;
        cfg_mode = md;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] acc;

        reset    = 1'b1;
        enable   = 4'b0000;
        sync     = 1'b0;
        start    = 4'b0000;
        cfg_we   = 1'b0;
        cfg_ch   = 3'd0;
        cfg_div  = 30'd0;
        cfg_mode = 1'b0;
        step();
        step();
        check_eq("rst_pulse", 32'(pulse), 32'd0);
        check_eq("rst_tick",  32'(tick),  32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);
        reset = 1'b0;

        // 1: ch0 periodic N=4
        enable = 4'b0001;
        do_cfg(3'd0, 30'd4, 1'b0);
        check_eq("t1_wr_pulse", 32'(pulse[0]), 32'd0);
        check_eq("t1_wr_tick",  32'(tick[0]),  32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq($sformatf("t1_tick_k%0d", k),  32'(tick[0]),  32'(k % 4 == 0));
            check_eq($sformatf("t1_pulse_k%0d", k), 32'(pulse[0]), 32'((k / 4) % 2));
            check_eq($sformatf("t1_busy_k%0d", k),  32'(busy[0]),  32'd0);
        end

        // 2: ch1 N=1 alongside ch0 (cnt0=0, pulse0=1 here), then pause both
        enable = 4'b0011;
        do_cfg(3'd1, 30'd1, 1'b0);
        for (int m = 1; m <= 3; m++) begin
            step();
            check_eq($sformatf("t2_tick1_m%0d", m),  32'(tick[1]),  32'd1);
            check_eq($sformatf("t2_pulse1_m%0d", m), 32'(pulse[1]), 32'(m % 2));
        end
        check_eq("t2_tick0_wrap",  32'(tick[0]),  32'd1);
        check_eq("t2_pulse0_wrap", 32'(pulse[0]), 32'd0);
        enable = 4'b0000;
        for (int p = 1; p <= 3; p++) begin
            step();
            check_eq($sformatf("t2_pause_tick_p%0d", p),  32'(tick[1:0]),  32'd0);
            check_eq($sformatf("t2_pause_pulse_p%0d", p), 32'(pulse[1:0]), 32'b10);
        end
        enable = 4'b0011;
        for (int p = 1; p <= 4; p++) begin
            step();
            check_eq($sformatf("t2_res_tick1_p%0d", p),  32'(tick[1]),  32'd1);
            check_eq($sformatf("t2_res_pulse1_p%0d", p), 32'(pulse[1]), 32'((p + 1) % 2));
            check_eq($sformatf("t2_res_tick0_p%0d", p),  32'(tick[0]),  32'(p == 4));
            check_eq($sformatf("t2_res_pulse0_p%0d", p), 32'(pulse[0]), 32'(p == 4));
        end
        enable = 4'b0000;

        // 3: ch2 one-shot N=5
        enable = 4'b0100;
        do_cfg(3'd2, 30'd5, 1'b1);
        check_eq("t3_idle_busy", 32'(busy[2]), 32'd0);
        start = 4'b0100;
        step();
        start = 4'b0000;
        check_eq("t3_st_busy",  32'(busy[2]),  32'd1);
        check_eq("t3_st_pulse", 32'(pulse[2]), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq($sformatf("t3a_busy_k%0d", k),  32'(busy[2]),  32'(k < 5));
            check_eq($sformatf("t3a_pulse_k%0d", k), 32'(pulse[2]), 32'(k < 5));
            check_eq($sformatf("t3a_tick_k%0d", k),  32'(tick[2]),  32'(k == 5));
        end
        // retrigger at cycle 3 extends the window to cycle 8
        start = 4'b0100;
        step();
        start = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            start = (k == 3) ? 4'b0100 : 4'b0000;
            step();
            start = 4'b0000;
            check_eq($sformatf("t3b_busy_k%0d", k), 32'(busy[2]), 32'(k < 8));
            check_eq($sformatf("t3b_tick_k%0d", k), 32'(tick[2]), 32'(k == 8));
        end
        // retrigger on the wrap cycle: tick fires, busy stays high
        start = 4'b0100;
        step();
        start = 4'b0000;
        for (int k = 1; k <= 11; k++) begin
            start = (k == 5) ? 4'b0100 : 4'b0000;
            step();
            start = 4'b0000;
            check_eq($sformatf("t3c_busy_k%0d", k), 32'(busy[2]), 32'(k < 10));
            check_eq($sformatf("t3c_tick_k%0d", k), 32'(tick[2]), 32'(k == 5 || k == 10));
        end

        // 4: ch0 N=3, ch1 N=6, sync, with an out-of-range cfg write mid-run
        enable = 4'b0000;
        do_cfg(3'd0, 30'd3, 1'b0);
        do_cfg(3'd1, 30'd6, 1'b0);
        enable = 4'b0011;
        for (int k = 1; k <= 4; k++) begin
            step();
        end
        check_eq("t4_presync_pulse0", 32'(pulse[0]), 32'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("t4_sync_pulse", 32'(pulse[1:0]), 32'd0);
        check_eq("t4_sync_tick",  32'(tick[1:0]),  32'd0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) begin
                do_cfg(3'd5, 30'd2, 1'b1);
            end else begin
                step();
            end
            check_eq($sformatf("t4_tick0_k%0d", k),  32'(tick[0]),  32'(k % 3 == 0));
            check_eq($sformatf("t4_tick1_k%0d", k),  32'(tick[1]),  32'(k % 6 == 0));
            check_eq($sformatf("t4_pulse0_k%0d", k), 32'(pulse[0]), 32'((k / 3) % 2));
            check_eq($sformatf("t4_pulse1_k%0d", k), 32'(pulse[1]), 32'((k / 6) % 2));
        end

        // 5: ch3 N=0 stalls
        enable = 4'b0000;
        do_cfg(3'd3, 30'd0, 1'b0);
        enable = 4'b1000;
        acc = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            step();
            acc = acc | {pulse[3], tick[3]};
        end
        check_eq("t5_div0_stall", 32'(acc), 32'd0);

        // 6: reset mid-operation
        enable = 4'b0101;
        start  = 4'b0100;
        step();
        start  = 4'b0000;
        step();
        check_eq("t6_pre_busy2", 32'(busy[2]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_rst_all", 32'({pulse, tick, busy}), 32'd0);
        enable = 4'b1111;
        start  = 4'b1111;
        step();
        start  = 4'b0000;
        check_eq("t6_mode0_busy",  32'(busy),  32'd0);
        check_eq("t6_mode0_pulse", 32'(pulse), 32'd0);
        acc = 2'b00;
        for (int k = 1; k <= 1000; k++) begin
            step();
            acc = acc | {|busy, |tick};
        end
        check_eq("t6_divrst_quiet", 32'(acc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised, multi-channel, programmable clock divider for board-level timebases such as LED blink, display refresh and debounce sampling.
- Each of NUM_CH channels divides the system clock by a run-time-programmable value.
- Each channel runs in one of two modes: a periodic toggling square wave, or a retriggerable one-shot timer.
- Every channel also gives a single-cycle tick strobe, and all channels can be phase-aligned with one global sync strobe.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 30, counter and divide-value width in bits.
- DIV_RST, 1073741823, divide value loaded into every channel at reset.
- CH_W, 2, channel-select width; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  NUM_CH  per-channel count enable; low pauses the channel.
- sync  in  1  global phase-align strobe.
- start  in  NUM_CH  per-channel one-shot trigger.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_div  in  CNT_W  new divide value N.
- cfg_mode  in  1  new mode: 0 = periodic, 1 = one-shot.
- pulse  out  NUM_CH  divided clock (periodic mode) or busy window (one-shot mode); registered.
- tick  out  NUM_CH  one-cycle strobe at each terminal count; registered.
- busy  out  NUM_CH  one-shot timer running; always 0 in periodic mode.

Behaviour:
- Reset, synchronous and active-high, applies to every channel:
  - cnt = 0, pulse = 0, tick = 0, busy = 0.
  - div = DIV_RST, mode = 0.
- Per-channel state: cnt, div, mode, plus the registered outputs pulse, tick and busy.
- Active condition:
  - periodic mode: enable[i] = 1 and div != 0.
  - one-shot mode: enable[i] = 1 and busy[i] = 1.
- Counting, per channel and per cycle while active:
  - if cnt == div-1: cnt <= 0 and a wrap event occurs.
  - otherwise: cnt <= cnt+1.
- Wrap event, registered on the same edge:
  - tick <= 1 for exactly the following cycle; otherwise tick <= 0.
  - Periodic mode: pulse <= ~pulse. Pulse period is 2N cycles at 50% duty; tick repeats every N cycles.
  - One-shot mode: busy <= 0 and pulse <= 0.
- First tick after entering the active state occurs N cycles later.
- Not active: cnt, pulse and busy hold their values; tick = 0.
- div = 0: channel stalled, cnt held at 0, no ticks, pulse holds.
- div = 1: tick high every cycle; in periodic mode pulse toggles every cycle.
- Counter arithmetic is unsigned CNT_W-bit. cnt never exceeds div-1 except right after a cfg write, which clears cnt to 0.
- One-shot start, start[i] = 1 in one-shot mode with div != 0:
  - cnt <= 0, busy <= 1, pulse <= 1.
  - Start while busy retriggers: cnt restarts at 0 and busy stays 1.
  - Start is ignored when div = 0 or in periodic mode.
  - Start on the same cycle as a wrap: retrigger wins (busy stays 1), but tick still fires.
- Configuration write, cfg_we = 1:
  - Addressed channel: div <= cfg_div, mode <= cfg_mode, cnt <= 0, pulse <= 0, busy <= 0, tick <= 0.
  - cfg_ch >= NUM_CH: write ignored.
  - Other channels are unaffected.
- sync = 1:
  - All channels: cnt <= 0, pulse <= 0, tick <= 0.
  - busy and configuration are unchanged; busy one-shots restart their count.
- Priority per channel: reset > cfg write > start > sync > counting.
  - cfg write and start on the same channel in the same cycle: the new config is applied, then start is evaluated against the new div and mode.
- Reset mid-operation aborts all counts and one-shots immediately; no tick is emitted.

Test Plan:
1. Reset, then cfg ch0 div=4 mode=0 with enable[0]=1 -> tick[0] high in cycles 4, 8, 12 after the write; pulse[0] rises at cycle 4, falls at cycle 8, period 8; busy[0]=0.
2. ch1 div=1 mode=0 with enable held, then enable[1] low for 3 cycles -> tick[1] high every enabled cycle; pulse[1] toggles every cycle; during the pause tick=0, pulse and cnt hold, and counting resumes without a phase jump.
3. ch2 div=5 mode=1, start[2] pulse -> busy and pulse high for 5 cycles, tick[2] once at cycle 5, then busy=0; a second start at cycle 3 extends busy to cycle 8.
4. ch0 div=3 and ch1 div=6 running with a sync pulse asserted -> both cnt=0 and pulse=0 next cycle; ch0 ticks 3 cycles later and ch1 6 cycles later, with coincident ticks every 6 cycles.
5. cfg ch3 div=0 then enable[3]=1 for 20 cycles -> no tick, pulse[3]=0; cfg with cfg_ch=5 when NUM_CH=4 -> no channel changes.
6. Reset asserted while ch2 one-shot is busy and ch0 is mid-period -> all outputs 0 next cycle, div reads back DIV_RST behaviour (no tick within 1000 cycles), mode=0.
